regfile_array: RTL



---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_array_write_decoder.sv | 55 +++++
 rtl/regfile_array.sv | 68 ++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the LEGv8 register file storage stage.
package regfile_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned ZERO_REG   = 31;

  typedef logic [XLEN-1:0]       reg_word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_array_write_decoder.sv
// Enabled one-hot write decoder: 2-to-4 predecode crossed with an enabled 3-to-8,
// three gate levels from address to load enable.
module write_decoder
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
  localparam int unsigned NUM_OUT   = 2**ADDR_WIDTH
) (
  input  logic                  i_en,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [NUM_OUT-1:0]    o_onehot
);

  generate
    if (ADDR_WIDTH == 5) begin : g_gates
      logic [4:0] w_addr_n;
      logic [3:0] w_pre_lo;
      logic [7:0] w_pre_hi;

      for (genvar b = 0; b < 5; b++) begin : g_inv
        not u_not (w_addr_n[b], i_addr[b]);
      end

      for (genvar j = 0; j < 4; j++) begin : g_lo
        localparam logic [1:0] SEL = 2'(j);
        and u_and (w_pre_lo[j],
                   SEL[0] ? i_addr[0] : w_addr_n[0],
                   SEL[1] ? i_addr[1] : w_addr_n[1]);
      end

      // Enable is folded into the high predecode so the final stage stays a 2-input AND.
      for (genvar k = 0; k < 8; k++) begin : g_hi
        localparam logic [2:0] SEL = 3'(k);
        and u_and (w_pre_hi[k], i_en,
                   SEL[0] ? i_addr[2] : w_addr_n[2],
                   SEL[1] ? i_addr[3] : w_addr_n[3],
                   SEL[2] ? i_addr[4] : w_addr_n[4]);
      end

      for (genvar k = 0; k < 8; k++) begin : g_row
        for (genvar j = 0; j < 4; j++) begin : g_col
          and u_and (o_onehot[k*4+j], w_pre_hi[k], w_pre_lo[j]);
        end
      end
    end else begin : g_behav
      always_comb begin
        o_onehot = '0;
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
          o_onehot[k] = i_en & (i_addr == ADDR_WIDTH'(k));
        end
      end
    end
  endgenerate

endmodule

// File: rtl/regfile_array.sv
// LEGv8 register array: 31 writable registers plus hardwired-zero X31, sticky X31-write flag.
// Optional same-cycle write-through on the regs view when REGFILE_WRITE_THROUGH_EN is defined.
module regfile_array
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] regs [0:2**ADDR_WIDTH-1],
  output logic                  zero_wr_seen
);

  localparam int unsigned NUM  = 2**ADDR_WIDTH;
  localparam int unsigned LAST = NUM - 1;

  logic [NUM-1:0]        w_we;
  logic [DATA_WIDTH-1:0] r_regs [0:LAST-1];
  logic                  r_zero_wr_seen;

  write_decoder #(.ADDR_WIDTH(ADDR_WIDTH)) u_dec (
    .i_en     (wr_en),
    .i_addr   (wr_addr),
    .o_onehot (w_we)
  );

  // Flop banks with per-register load enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned n = 0; n < LAST; n++) begin
        r_regs[n] <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < LAST; n++) begin
        if (w_we[n]) begin
          r_regs[n] <= wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero_wr_seen <= 1'b0;
    end else if (w_we[LAST]) begin
      r_zero_wr_seen <= 1'b1;
    end
  end

  assign zero_wr_seen = r_zero_wr_seen;

  always_comb begin
    for (int unsigned n = 0; n < LAST; n++) begin
      regs[n] = r_regs[n];
`ifdef REGFILE_WRITE_THROUGH_EN
      if (w_we[n]) begin
        regs[n] = wr_data;
      end
`endif
    end
    regs[LAST] = '0;
  end

endmodule
